// File: rtl/mkio_pkg.sv
// Shared types and defaults for the MKIO Manchester receiver.
// Holds the line-level and FSM state encodings.
package mkio_pkg;

    localparam int HALF_BIT_DEF = 8;
    localparam int SYNC_TOL_DEF = 4;
    localparam int WORD_BITS    = 17;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_A,
        SYNC_B,
        DATA,
        WAIT_NULL
    } state_e;

    typedef enum logic [1:0] {
        LV_N,
        LV_H,
        LV_L
    } level_e;

endpackage

// File: rtl/mkio_line_sync.sv
// Two-flop synchronizers on both line legs and H/L/N level decode.
// Everything downstream sees only the synchronized level.
module mkio_line_sync
    import mkio_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   di1_i,
    input  logic   di0_i,
    output level_e lvl_o
);

    logic [1:0] d1_q;
    logic [1:0] d0_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d1_q <= '0;
            d0_q <= '0;
        end else begin
            d1_q <= {d1_q[0], di1_i};
            d0_q <= {d0_q[0], di0_i};
        end
    end

    always_comb begin
        unique case ({d1_q[1], d0_q[1]})
            2'b10:   lvl_o = LV_H;
            2'b01:   lvl_o = LV_L;
            default: lvl_o = LV_N;
        endcase
    end

endmodule

// File: rtl/mkio_receiver.sv
// MKIO Manchester word receiver: sync detection, 17-bit fixed-timeline
// sampling from the sync edge, parity and encoding error flags.
module mkio_receiver
    import mkio_pkg::*;
#(
    parameter int HALF_BIT = HALF_BIT_DEF,
    parameter int SYNC_TOL = SYNC_TOL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI1,
    input  logic        DI0,
    output logic [15:0] data_rcv,
    output logic        cd_rcv,
    output logic        imp_rcv,
    output logic        err_parity,
    output logic        err_manch,
    output logic        busy_rcv
);

    localparam int CW = $clog2(3 * HALF_BIT + SYNC_TOL + 2);

    localparam logic [CW-1:0] SYNC_LO = CW'(3 * HALF_BIT - SYNC_TOL);
    localparam logic [CW-1:0] SYNC_HI = CW'(3 * HALF_BIT + SYNC_TOL);
    localparam logic [CW-1:0] SB_SAMP = CW'(3 * HALF_BIT / 2);
    localparam logic [CW-1:0] SB_END  = CW'(3 * HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_S1  = CW'(HALF_BIT / 2);
    localparam logic [CW-1:0] BIT_S2  = CW'(3 * HALF_BIT / 2);
    localparam logic [CW-1:0] BIT_END = CW'(2 * HALF_BIT - 1);
    localparam logic [4:0]    LAST_BIT = 5'(WORD_BITS - 1);

    level_e lvl;

    mkio_line_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .di1_i (DI1),
        .di0_i (DI0),
        .lvl_o (lvl)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    level_e        pol_q, pol_d;
    level_e        s1_q, s1_d;
    logic [15:0]   shift_q, shift_d;
    logic          manch_q, manch_d;

    logic [15:0]   data_q;
    logic          cd_q, imp_q, errp_q, errm_q;

    level_e        lvl_inv;
    logic          pair_one, pair_zero, done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pol_q   <= LV_N;
            s1_q    <= LV_N;
            shift_q <= '0;
            manch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pol_q   <= pol_d;
            s1_q    <= s1_d;
            shift_q <= shift_d;
            manch_q <= manch_d;
        end
    end

    assign lvl_inv   = (pol_q == LV_H) ? LV_L : LV_H;
    assign pair_one  = (s1_q == LV_H) && (lvl == LV_L);
    assign pair_zero = (s1_q == LV_L) && (lvl == LV_H);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pol_d   = pol_q;
        s1_d    = s1_q;
        shift_d = shift_q;
        manch_d = manch_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lvl != LV_N) begin
                    pol_d   = lvl;
                    cnt_d   = CW'(1);
                    state_d = SYNC_A;
                end
            end
            SYNC_A: begin
                if (lvl == pol_q && cnt_q < SYNC_HI) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (lvl == lvl_inv && cnt_q >= SYNC_LO
                             && cnt_q <= SYNC_HI) begin
                    // cnt counts cycles since reference cycle T
                    cnt_d   = CW'(1);
                    bit_d   = '0;
                    shift_d = '0;
                    manch_d = 1'b0;
                    state_d = SYNC_B;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_NULL;
                end
            end
            SYNC_B: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SB_SAMP && lvl != lvl_inv) begin
                    cnt_d   = '0;
                    state_d = WAIT_NULL;
                end else if (cnt_q == SB_END) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_S1) begin
                    s1_d = lvl;
                end
                if (cnt_q == BIT_S2) begin
                    if (!(pair_one || pair_zero)) begin
                        manch_d = 1'b1;
                    end
                    if (bit_q == LAST_BIT) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_NULL;
                    end else begin
                        shift_d = {shift_q[14:0], pair_one};
                    end
                end
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                end
            end
            WAIT_NULL: begin
                if (lvl != LV_N) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Result registers change only on a completed word
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            cd_q   <= 1'b0;
            imp_q  <= 1'b0;
            errp_q <= 1'b0;
            errm_q <= 1'b0;
        end else begin
            imp_q <= done;
            if (done) begin
                data_q <= shift_q;
                cd_q   <= (pol_q == LV_L);
                errp_q <= ~(^{shift_q, pair_one});
                errm_q <= manch_q | ~(pair_one | pair_zero);
            end
        end
    end

    always_comb begin
        busy_rcv   = (state_q == SYNC_B) || (state_q == DATA);
        data_rcv   = data_q;
        cd_rcv     = cd_q;
        imp_rcv    = imp_q;
        err_parity = errp_q;
        err_manch  = errm_q;
    end

endmodule
